// File: rtl/rename_pkg.sv
// ============================================================================
//  Module      : rename_pkg
//  Description : Shared rename-stage constants and types. The free list,
//                ROB and rename map table all use preg_t for physical
//                register numbers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rename_pkg;

    localparam int NUM_PREGS    = 64;   // physical registers, power of two
    localparam int NUM_AREGS    = 32;   // architectural registers
    localparam int RENAME_WIDTH = 2;    // allocate/free slots per cycle

    localparam int PREG_W       = $clog2(NUM_PREGS);

    typedef logic [PREG_W-1:0] preg_t;
    typedef logic [PREG_W:0]   fl_count_t;

    // Free entries right after reset: every register not holding an
    // architectural mapping.
    localparam fl_count_t C_FL_RESET_COUNT = fl_count_t'(NUM_PREGS - NUM_AREGS);

endpackage : rename_pkg

`default_nettype wire

// File: rtl/freelist_if.sv
// ============================================================================
//  Module      : freelist_if
//  Description : Rename/commit <-> free list connection.
//                master : rename + commit side (drives requests and frees)
//                slave  : the free list itself
//  Signals     : alloc_req      per-slot allocation request
//                alloc_preg     granted physical register per slot
//                freelist_empty fewer than RENAME_WIDTH entries free
//                free_en        per-slot release from commit
//                free_preg      physical register released per slot
//                count          number of free entries
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface freelist_if;
    import rename_pkg::*;

    logic  [RENAME_WIDTH-1:0]        alloc_req;
    preg_t [RENAME_WIDTH-1:0]        alloc_preg;
    logic                            freelist_empty;
    logic  [RENAME_WIDTH-1:0]        free_en;
    preg_t [RENAME_WIDTH-1:0]        free_preg;
    fl_count_t                       count;

    modport master (
        output alloc_req,
        output free_en,
        output free_preg,
        input  alloc_preg,
        input  freelist_empty,
        input  count
    );

    modport slave (
        input  alloc_req,
        input  free_en,
        input  free_preg,
        output alloc_preg,
        output freelist_empty,
        output count
    );

endinterface : freelist_if

`default_nettype wire

// File: rtl/freelist.sv
// ============================================================================
//  Module      : freelist
//  Description : Physical-register free list. Circular FIFO of free register
//                numbers; rename pops up to RENAME_WIDTH per cycle from the
//                head, commit pushes up to RENAME_WIDTH per cycle at the tail.
//  Ports       : clk  - clock
//                rst  - synchronous active-high reset
//                fl   - freelist_if.slave (requests, grants, frees, status)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module freelist
    import rename_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   rst,
    freelist_if.slave   fl
);

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    // Number of set bits in v[k-1:0]; gives each slot its compacted offset.
    function automatic fl_count_t popcount_below(
        input logic [RENAME_WIDTH-1:0] v,
        input int                      k
    );
        fl_count_t n;
        n = '0;
        for (int j = 0; j < RENAME_WIDTH; j++) begin
            if (j < k && v[j]) begin
                n = n + fl_count_t'(1);
            end
        end
        return n;
    endfunction

    // Pointer plus offset; NUM_PREGS is a power of two so truncation wraps.
    function automatic preg_t ptr_add(input preg_t p, input fl_count_t off);
        return p + preg_t'(off);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    preg_t     r_mem [NUM_PREGS];
    preg_t     r_head;
    preg_t     r_tail;
    fl_count_t r_count;

    logic                     w_empty;
    fl_count_t                w_nalloc;
    fl_count_t                w_nfree;
    fl_count_t                w_nfree_req;
    logic                     w_overflow;
    logic  [RENAME_WIDTH-1:0] w_wr_en;
    preg_t [RENAME_WIDTH-1:0] w_wr_idx;

    // ------------------------------------------------------------------
    // Allocation side: grants are read straight from the array at the
    // compacted head offset. Empty is decoded from registered count only,
    // so same-cycle frees never make a register allocatable.
    // ------------------------------------------------------------------
    always_comb begin
        w_empty       = (r_count < fl_count_t'(RENAME_WIDTH));
        w_nalloc      = w_empty ? '0 : popcount_below(fl.alloc_req, RENAME_WIDTH);
        fl.alloc_preg = '0;
        for (int k = 0; k < RENAME_WIDTH; k++) begin
            fl.alloc_preg[k] = r_mem[ptr_add(r_head, popcount_below(fl.alloc_req, k))];
        end
    end

    // ------------------------------------------------------------------
    // Free side: p0 releases are dropped (x0 never allocates). Frees beyond
    // the remaining capacity are discarded; lower slots claim room first,
    // so the highest slot is the one lost.
    // ------------------------------------------------------------------
    always_comb begin
        w_nfree     = '0;
        w_nfree_req = '0;
        w_wr_en     = '0;
        w_wr_idx    = '0;
        for (int k = 0; k < RENAME_WIDTH; k++) begin
            w_wr_idx[k] = ptr_add(r_tail, w_nfree);
            if (fl.free_en[k] && (fl.free_preg[k] != '0)) begin
                w_nfree_req = w_nfree_req + fl_count_t'(1);
                if ((r_count + w_nfree) < fl_count_t'(NUM_PREGS)) begin
                    w_wr_en[k] = 1'b1;
                    w_nfree    = w_nfree + fl_count_t'(1);
                end
            end
        end
        w_overflow = ((r_count + w_nfree_req) > fl_count_t'(NUM_PREGS));
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= preg_t'(NUM_PREGS - NUM_AREGS);
            r_count <= C_FL_RESET_COUNT;
            for (int i = 0; i < NUM_PREGS - NUM_AREGS; i++) begin
                r_mem[i] <= preg_t'(NUM_AREGS + i);
            end
        end else begin
            r_head  <= ptr_add(r_head, w_nalloc);
            r_tail  <= ptr_add(r_tail, w_nfree);
            r_count <= r_count + w_nfree - w_nalloc;
            for (int k = 0; k < RENAME_WIDTH; k++) begin
                if (w_wr_en[k]) begin
                    r_mem[w_wr_idx[k]] <= fl.free_preg[k];
                end
            end
        end
    end

    assign fl.freelist_empty = w_empty;
    assign fl.count          = r_count;

    // Commit must never release more registers than there are free slots.
    a_no_free_overflow: assert property (@(posedge clk) disable iff (rst) !w_overflow);

endmodule : freelist

`default_nettype wire

// File: tb/tb_freelist.sv
// ============================================================================
//  Module      : tb_freelist
//  Description : Self-checking bench for freelist: directed vector table,
//                then queue-model sequences for wrap, random traffic and
//                mid-stream reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_freelist;
    import rename_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    freelist_if fl_if ();

    freelist dut (
        .clk (clk),
        .rst (rst),
        .fl  (fl_if.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0] req;
        logic [1:0] fen;
        int         fp0;
        int         fp1;
        logic [1:0] chk;
        int         ep0;
        int         ep1;
        int         ecount;
        int         eempty;
    } vec_t;

    vec_t vq[$];
    int   mq[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] req, input logic [1:0] fen,
                         input int fp0, input int fp1);
        fl_if.alloc_req    = req;
        fl_if.free_en      = fen;
        fl_if.free_preg[0] = preg_t'(fp0);
        fl_if.free_preg[1] = preg_t'(fp1);
    endtask

    task automatic add(input logic [1:0] req, input logic [1:0] fen, input int fp0,
                       input int fp1, input logic [1:0] chk, input int ep0,
                       input int ep1, input int ecount, input int eempty);
        vec_t v;
        v.req = req; v.fen = fen; v.fp0 = fp0; v.fp1 = fp1; v.chk = chk;
        v.ep0 = ep0; v.ep1 = ep1; v.ecount = ecount; v.eempty = eempty;
        vq.push_back(v);
    endtask

    // One cycle against the FIFO-order queue model.
    task automatic model_cycle(input logic [1:0] req, input logic [1:0] fen,
                               input int fp0, input int fp1, input string tag);
        int idx;
        int base;
        int pushed;
        bit emp;
        int fp[2];
        emp   = (mq.size() < 2);
        base  = mq.size();
        fp[0] = fp0;
        fp[1] = fp1;
        @(negedge clk);
        drive(req, fen, fp0, fp1);
        #1;
        idx = 0;
        if (!emp) begin
            for (int k = 0; k < 2; k++) begin
                if (req[k]) begin
                    check($sformatf("%s preg%0d", tag, k), int'(fl_if.alloc_preg[k]), mq[idx]);
                    idx++;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < idx; k++) void'(mq.pop_front());
        pushed = 0;
        for (int k = 0; k < 2; k++) begin
            if (fen[k] && fp[k] != 0 && (base + pushed) < NUM_PREGS) begin
                mq.push_back(fp[k]);
                pushed++;
            end
        end
        check($sformatf("%s count", tag), int'(fl_if.count), mq.size());
        check($sformatf("%s empty", tag), int'(fl_if.freelist_empty), (mq.size() < 2) ? 1 : 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- directed table ----------------
        for (int i = 0; i < 16; i++) begin
            add(2'b11, 2'b00, 0, 0, 2'b11, 32 + 2*i, 33 + 2*i, 30 - 2*i, (i == 15) ? 1 : 0);
        end
        add(2'b11, 2'b00,  0,  0, 2'b00,  0,  0, 0, 1); // empty: request ignored
        add(2'b00, 2'b11, 10, 11, 2'b00,  0,  0, 2, 0);
        add(2'b11, 2'b01,  5, 40, 2'b11, 10, 11, 1, 1); // alloc+free same cycle
        add(2'b00, 2'b01,  7, 50, 2'b00,  0,  0, 2, 0);
        add(2'b11, 2'b00,  0,  0, 2'b11,  5,  7, 0, 1);
        add(2'b00, 2'b11, 13, 12, 2'b00,  0,  0, 2, 0);
        add(2'b10, 2'b00,  0,  0, 2'b10,  0, 13, 1, 1); // slot 1 alone gets head
        add(2'b00, 2'b10, 20, 14, 2'b00,  0,  0, 2, 0); // slot 1 free at tail
        add(2'b00, 2'b11,  0,  9, 2'b00,  0,  0, 3, 0); // p0 dropped
        add(2'b01, 2'b00,  0,  0, 2'b01, 12,  0, 2, 0);
        add(2'b11, 2'b00,  0,  0, 2'b11, 14,  9, 0, 1);

        // ---------------- reset state ----------------
        rst = 1'b1;
        drive(2'b00, 2'b00, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset count", int'(fl_if.count), 32);
        check("reset empty", int'(fl_if.freelist_empty), 0);
        check("reset head preg", int'(fl_if.alloc_preg[0]), 32);

        foreach (vq[i]) begin
            @(negedge clk);
            rst = 1'b0;
            drive(vq[i].req, vq[i].fen, vq[i].fp0, vq[i].fp1);
            #1;
            if (vq[i].chk[0]) check($sformatf("v%0d preg0", i), int'(fl_if.alloc_preg[0]), vq[i].ep0);
            if (vq[i].chk[1]) check($sformatf("v%0d preg1", i), int'(fl_if.alloc_preg[1]), vq[i].ep1);
            @(posedge clk);
            #1;
            check($sformatf("v%0d count", i), int'(fl_if.count), vq[i].ecount);
            check($sformatf("v%0d empty", i), int'(fl_if.freelist_empty), vq[i].eempty);
        end

        // ---------------- wrap: more than 64 entries through ----------------
        for (int i = 0; i < 40; i++) begin
            model_cycle(2'b11, 2'b11, 1 + (2*i) % 63, 1 + (2*i + 1) % 63, $sformatf("wrap%0d", i));
        end

        // ---------------- random traffic ----------------
        for (int i = 0; i < 120; i++) begin
            logic [1:0] rq;
            logic [1:0] fe;
            rq = 2'($urandom_range(0, 3));
            fe = (mq.size() <= 60) ? 2'($urandom_range(0, 3)) : 2'b00;
            model_cycle(rq, fe, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                        $sformatf("rnd%0d", i));
        end

        // ---------------- mid-stream reset overrides requests ----------------
        @(negedge clk);
        rst = 1'b1;
        drive(2'b11, 2'b11, 3, 4);
        @(posedge clk);
        #1;
        check("midrst count", int'(fl_if.count), 32);
        check("midrst empty", int'(fl_if.freelist_empty), 0);
        @(negedge clk);
        rst = 1'b0;
        drive(2'b01, 2'b00, 0, 0);
        #1;
        check("midrst preg0", int'(fl_if.alloc_preg[0]), 32);
        @(posedge clk);
        #1;
        check("midrst count after", int'(fl_if.count), 31);
        @(negedge clk);
        drive(2'b00, 2'b00, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_freelist

`default_nettype wire
